// File: rtl/spi_readback_tx_pkg.sv
// Shared constants for the Nexys4 display SPI slave (receiver and readback transmitter).
package spi_readback_tx_pkg;

    localparam int BYTE_WIDTH    = 8;
    localparam int NUM_REGISTERS = 9;
    localparam int FRAME_CNT_W   = 3;

    localparam logic [3:0] STATUS_TAG = 4'hA;

    localparam logic [3:0] CMD_WRITE  = 4'b0001;
    localparam logic [3:0] CMD_READ   = 4'b0010;
    localparam logic [3:0] CMD_STATUS = 4'b0011;

    // bit_cnt values at which the transmit register is parallel-loaded
    localparam logic [3:0] CMD_LAST_BIT   = 4'd7;
    localparam logic [3:0] FRAME_LAST_BIT = 4'd15;

    // Status byte seen by the master straight after reset
    localparam logic [BYTE_WIDTH-1:0] STATUS_RESET = {STATUS_TAG, 4'h0};

    // Status byte: tag, validity of the previous frame's command, frame counter
    function automatic logic [BYTE_WIDTH-1:0] status_byte(input logic last_valid,
                                                         input logic [FRAME_CNT_W-1:0] frame_count);
        return {STATUS_TAG, last_valid, frame_count};
    endfunction

    // True for the command codes the peripheral recognises
    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_STATUS);
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// 8-bit parallel-load shift register feeding a negedge MISO flop.
module spi_tx_shifter
    import spi_readback_tx_pkg::*;
#(
    parameter logic [BYTE_WIDTH-1:0] RESET_VALUE = STATUS_RESET
) (
    input  logic                  spi_sclk_i,
    input  logic                  rst_low_i,
    input  logic                  load,
    input  logic                  shift,
    input  logic [BYTE_WIDTH-1:0] load_data,
    output logic                  miso_r
);

    logic [BYTE_WIDTH-1:0] tx_shift;

    // Load a new byte or move the next bit into the MSB, filling with 1s
    always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            tx_shift <= RESET_VALUE;
        end else if (load) begin
            tx_shift <= load_data;
        end else if (shift) begin
            tx_shift <= {tx_shift[BYTE_WIDTH-2:0], 1'b1};
        end
    end

    // Present the MSB half a cycle ahead of the master's posedge sample
    always_ff @(negedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            miso_r <= 1'b1;
        end else begin
            miso_r <= tx_shift[BYTE_WIDTH-1];
        end
    end

endmodule

// File: rtl/spi_readback_tx.sv
// SPI slave transmit stage: decodes the command byte and returns register or status data.
module spi_readback_tx
    import spi_readback_tx_pkg::*;
(
    input  logic                                spi_sclk_i,
    input  logic                                rst_low_i,
    input  logic                                spi_ss_i,
    input  logic                                spi_mosi_i,
    input  logic [BYTE_WIDTH*NUM_REGISTERS-1:0] reg_data_i,
    output logic                                spi_miso_o,
    output logic [FRAME_CNT_W-1:0]              frame_count_o
);

    logic [3:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [3:0]             cmd_r;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   last_valid;
    logic                   cnt_clr_n;
    logic [BYTE_WIDTH-1:0]  cmd_byte;
    logic [3:0]             cmd;
    logic [3:0]             addr;
    logic [BYTE_WIDTH-1:0]  rd_byte;
    logic [BYTE_WIDTH-1:0]  resp_byte;
    logic [BYTE_WIDTH-1:0]  load_data;
    logic                   at_cmd_end;
    logic                   at_frame_end;
    logic                   tx_load;
    logic                   tx_shift_en;
    logic                   miso_r;
    logic                   last_valid_nxt;
    logic [FRAME_CNT_W-1:0] frame_count_nxt;

    // Deasserting slave select aborts a frame by clearing the bit counter
    assign cnt_clr_n = rst_low_i & ~spi_ss_i;

    assign cmd_byte     = {rx_shift, spi_mosi_i};
    assign cmd          = cmd_byte[7:4];
    assign addr         = cmd_byte[3:0];
    assign at_cmd_end   = (bit_cnt == CMD_LAST_BIT);
    assign at_frame_end = (bit_cnt == FRAME_LAST_BIT);
    assign tx_load      = ~spi_ss_i & (at_cmd_end | at_frame_end);
    assign tx_shift_en  = ~spi_ss_i & ~at_cmd_end & ~at_frame_end;

    assign last_valid_nxt  = cmd_is_valid(cmd_r);
    assign frame_count_nxt = frame_count + 1'b1;

    // Bit position within the 16-bit frame; wraps so frames can run back to back
    always_ff @(posedge spi_sclk_i or negedge cnt_clr_n) begin
        if (!cnt_clr_n) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Collect the first seven command bits; the eighth is taken live from MOSI
    always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            rx_shift <= '0;
        end else if (!spi_ss_i) begin
            rx_shift <= {rx_shift[5:0], spi_mosi_i};
        end
    end

    // Remember the command and update frame statistics when a frame completes
    always_ff @(posedge spi_sclk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            cmd_r       <= '0;
            frame_count <= '0;
            last_valid  <= 1'b0;
        end else if (!spi_ss_i) begin
            if (at_cmd_end) begin
                cmd_r <= cmd;
            end
            if (at_frame_end) begin
                frame_count <= frame_count_nxt;
                last_valid  <= last_valid_nxt;
            end
        end
    end

    // Select the response byte and the byte to load into the transmit register
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            if (addr == 4'(i)) begin
                rd_byte = reg_data_i[BYTE_WIDTH*i +: BYTE_WIDTH];
            end
        end
        case (cmd)
            CMD_READ:   resp_byte = rd_byte;
            CMD_STATUS: resp_byte = status_byte(last_valid, frame_count);
            CMD_WRITE:  resp_byte = '0;
            default:    resp_byte = '1;
        endcase
        // At frame end the status shown next must already include this frame
        load_data = at_frame_end ? status_byte(last_valid_nxt, frame_count_nxt) : resp_byte;
    end

    spi_tx_shifter #(
        .RESET_VALUE (STATUS_RESET)
    ) u_tx_shifter (
        .spi_sclk_i (spi_sclk_i),
        .rst_low_i  (rst_low_i),
        .load       (tx_load),
        .shift      (tx_shift_en),
        .load_data  (load_data),
        .miso_r     (miso_r)
    );

    assign spi_miso_o    = spi_ss_i ? 1'b1 : miso_r;
    assign frame_count_o = frame_count;

endmodule
